// File: rtl/uart_rx_fifo_param.sv
// UART receiver with configurable frame format, own bit timing, sticky error flags
// and a first-word-fall-through receive FIFO.
module uart_rx_fifo_param #(
    parameter int CLK_DIV    = 434,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int AE_TH      = 1,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 rx_serial_data,
    input  logic                 rd_en,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] dout,
    output logic                 empty,
    output logic                 almost_empty,
    output logic                 full,
    output logic [AW:0]          count,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW   = $clog2(CLK_DIV + 1);
    localparam int CNTW = AW + 1;
    localparam logic [CW-1:0]   HALF_BIT  = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0]   FULL_BIT  = CW'(CLK_DIV);
    localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [CNTW-1:0] DEPTH_W   = CNTW'(FIFO_DEPTH);
    localparam logic [CNTW-1:0] AE_W      = CNTW'(AE_TH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HI} state_t;

    state_t                 state, next_state;
    logic                   sync1, sync2, prev;
    logic                   fall, tick;
    logic [CW-1:0]          bit_timer;
    logic [3:0]             bit_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   par_bad, stop_bad;
    logic                   push_req, set_pe, set_fe, set_ov;
    logic                   do_push, do_pop;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];

    assign fall = prev & ~sync2;
    assign tick = (bit_timer == CW'(1));

    // The synchroniser and edge register idle high so a line held low out of reset
    // only starts a frame through a genuine 1-to-0 step of the synchronised value.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rx_serial_data;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        push_req   = 1'b0;
        set_pe     = 1'b0;
        set_fe     = 1'b0;
        case (state)
            IDLE:    if (fall) next_state = START;
            START:   if (tick) next_state = sync2 ? IDLE : DATA;
            DATA:    if (tick && bit_idx == LAST_DATA) next_state = (PARITY != 0) ? PAR : STOP;
            PAR:     if (tick) next_state = STOP;
            STOP: begin
                // Frame decision at the final stop sample; framing beats parity.
                if (tick && bit_idx == LAST_STOP) begin
                    if (stop_bad || !sync2) begin
                        set_fe     = 1'b1;
                        next_state = WAIT_HI;
                    end else if (par_bad) begin
                        set_pe     = 1'b1;
                        next_state = IDLE;
                    end else begin
                        push_req   = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            WAIT_HI: if (sync2) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            bit_timer <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            par_bad   <= 1'b0;
            stop_bad  <= 1'b0;
        end else if (state == IDLE) begin
            bit_idx  <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            if (fall) bit_timer <= HALF_BIT;
        end else if (state != WAIT_HI) begin
            bit_timer <= tick ? FULL_BIT : bit_timer - CW'(1);
            if (tick) begin
                if (state == DATA) begin
                    shift   <= {sync2, shift[DATA_BITS-1:1]};
                    bit_idx <= (bit_idx == LAST_DATA) ? 4'd0 : bit_idx + 4'd1;
                end else if (state == PAR) begin
                    par_bad <= (PARITY == 1) ? ~(^shift ^ sync2) : (^shift ^ sync2);
                end else if (state == STOP) begin
                    if (!sync2) stop_bad <= 1'b1;
                    bit_idx <= bit_idx + 4'd1;
                end
            end
        end
    end

    // A full FIFO still takes a byte when the consumer pops in the same cycle.
    assign do_pop  = rd_en & ~empty;
    assign do_push = push_req & (~full | rd_en);
    assign set_ov  = push_req & full & ~rd_en;

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_W);
    assign almost_empty = (count <= AE_W);
    assign dout         = empty ? '0 : mem[rd_ptr];

    // Sticky flags; a new error in the clearing cycle survives the clear.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= set_pe | (parity_err & ~err_clr);
            frame_err  <= set_fe | (frame_err & ~err_clr);
            overrun    <= set_ov | (overrun & ~err_clr);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Bench for uart_rx_fifo_param: an 8N1 depth-4 instance and a 7E2 depth-16 instance
// driven by serialised frames and compared against queue-based models.
module tb_uart_rx_fifo_param;

    localparam int DIV   = 16;
    localparam int LAT_A = 3 + DIV / 2 + DIV * (8 + 0 + 1);
    localparam int LAT_B = 3 + DIV / 2 + DIV * (7 + 1 + 2);

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       line_a = 1'b1, rd_a = 1'b0, clr_a = 1'b0;
    logic       line_b = 1'b1, rd_b = 1'b0, clr_b = 1'b0;
    logic [7:0] dout_a;
    logic [2:0] count_a;
    logic       empty_a, ae_a, full_a, pe_a, fe_a, ov_a;
    logic [6:0] dout_b;
    logic [4:0] count_b;
    logic       empty_b, ae_b, full_b, pe_b, fe_b, ov_b;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q_a[$];
    logic [6:0] q_b[$];
    logic       ov_model, pe_model;

    typedef struct {
        bit         is_read;
        logic [7:0] data;
        int         exp_count;
        logic [7:0] exp_dout;
        bit         exp_full;
        bit         exp_ov;
    } vec_t;

    vec_t tbl[11];

    uart_rx_fifo_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                         .FIFO_DEPTH(4), .AE_TH(1)) dut_a (
        .clk_in(clk_in), .rst(rst), .rx_serial_data(line_a), .rd_en(rd_a), .err_clr(clr_a),
        .dout(dout_a), .empty(empty_a), .almost_empty(ae_a), .full(full_a), .count(count_a),
        .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a));

    uart_rx_fifo_param #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                         .FIFO_DEPTH(16), .AE_TH(2)) dut_b (
        .clk_in(clk_in), .rst(rst), .rx_serial_data(line_b), .rd_en(rd_b), .err_clr(clr_b),
        .dout(dout_b), .empty(empty_b), .almost_empty(ae_b), .full(full_b), .count(count_b),
        .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b));

    always #5 clk_in = ~clk_in;

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int expected);
        n_vec++;
        if (actual < expected - 2 || actual > expected + 2) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d cycles, expected %0d +/- 2", name, actual, expected);
        end
    endtask

    task automatic check_a(input string tag, input int cnt, input logic [7:0] d, input bit f, input bit ov);
        checkOutput({tag, " count"}, 32'(count_a), cnt);
        checkOutput({tag, " dout"}, 32'(dout_a), 32'(d));
        checkOutput({tag, " empty"}, 32'(empty_a), 32'(cnt == 0));
        checkOutput({tag, " almost_empty"}, 32'(ae_a), 32'(cnt <= 1));
        checkOutput({tag, " full"}, 32'(full_a), 32'(f));
        checkOutput({tag, " overrun"}, 32'(ov_a), 32'(ov));
    endtask

    task automatic check_b(input string tag, input int cnt, input logic [6:0] d, input bit pe);
        checkOutput({tag, " count"}, 32'(count_b), cnt);
        checkOutput({tag, " dout"}, 32'(dout_b), 32'(d));
        checkOutput({tag, " empty"}, 32'(empty_b), 32'(cnt == 0));
        checkOutput({tag, " almost_empty"}, 32'(ae_b), 32'(cnt <= 2));
        checkOutput({tag, " parity_err"}, 32'(pe_b), 32'(pe));
        checkOutput({tag, " frame_err"}, 32'(fe_b), 0);
    endtask

    function automatic logic [15:0] frame_a(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame_b(input logic [6:0] d, input bit bad);
        logic par;
        par = (^d) ^ bad;
        return {5'b0, 2'b11, par, d, 1'b0};
    endfunction

    function automatic logic [31:0] sig(input int which);
        return (which == 0) ? {26'b0, count_a, pe_a, fe_a, ov_a} : {24'b0, count_b, pe_b, fe_b, ov_b};
    endfunction

    // Drive nbits serial bits, LSB first, one bit time each; call at a negedge.
    task automatic applyStimulus(input int which, input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (which == 0) line_a = bits[i];
            else            line_b = bits[i];
            repeat (DIV) @(negedge clk_in);
        end
    endtask

    task automatic send_frame(input int which, input logic [15:0] bits, input int nbits, output int lat);
        logic [31:0] sig0;
        int          l;
        sig0 = sig(which);
        l    = -1;
        fork
            applyStimulus(which, bits, nbits);
            begin
                for (int c = 1; c <= 200; c++) begin
                    @(posedge clk_in);
                    #1;
                    if (sig(which) !== sig0 && l < 0) l = c;
                end
            end
        join
        @(negedge clk_in);
        lat = l;
    endtask

    task automatic do_read(input int which);
        if (which == 0) rd_a = 1'b1;
        else            rd_b = 1'b1;
        @(negedge clk_in);
        rd_a = 1'b0;
        rd_b = 1'b0;
    endtask

    task automatic pulse_clr(input int which);
        if (which == 0) clr_a = 1'b1;
        else            clr_b = 1'b1;
        @(negedge clk_in);
        clr_a = 1'b0;
        clr_b = 1'b0;
    endtask

    function automatic logic [7:0] head_a();
        return (q_a.size() > 0) ? q_a[0] : 8'h00;
    endfunction

    function automatic logic [6:0] head_b();
        return (q_b.size() > 0) ? q_b[0] : 7'h00;
    endfunction

    initial begin
        int         lat;
        logic [7:0] d8;
        logic [6:0] d7;
        bit         bad;

        tbl[0]  = '{1'b0, 8'hA5, 1, 8'hA5, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'h01, 1, 8'h01, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h02, 2, 8'h01, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h03, 3, 8'h01, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h04, 4, 8'h01, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'h05, 4, 8'h01, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 8'h00, 3, 8'h02, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 8'h00, 2, 8'h03, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 8'h00, 1, 8'h04, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b1};

        repeat (3) @(negedge clk_in);
        check_a("reset", 0, 8'h00, 1'b0, 1'b0);
        check_b("reset", 0, 7'h00, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk_in);
        check_a("idle", 0, 8'h00, 1'b0, 1'b0);

        // Table: single byte, fill to full, overrun, drain
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].is_read) begin
                do_read(0);
            end else begin
                send_frame(0, frame_a(tbl[i].data), 10, lat);
                checkRange($sformatf("vec%0d latency", i), lat, LAT_A);
            end
            check_a($sformatf("vec%0d", i), tbl[i].exp_count, tbl[i].exp_dout, tbl[i].exp_full, tbl[i].exp_ov);
        end
        pulse_clr(0);
        checkOutput("overrun cleared", 32'(ov_a), 0);

        $display("[TB] glitch and framing error");
        line_a = 1'b0;
        repeat (4) @(negedge clk_in);
        line_a = 1'b1;
        repeat (40) @(negedge clk_in);
        check_a("glitch", 0, 8'h00, 1'b0, 1'b0);
        checkOutput("glitch flags", {29'b0, pe_a, fe_a, ov_a}, 0);

        send_frame(0, {4'b0, 3'b000, 8'h55, 1'b0}, 12, lat);
        checkOutput("break frame_err", 32'(fe_a), 1);
        checkOutput("break count", 32'(count_a), 0);
        repeat (3 * DIV) @(negedge clk_in);
        checkOutput("break held count", 32'(count_a), 0);
        line_a = 1'b1;
        repeat (20) @(negedge clk_in);
        checkOutput("break release count", 32'(count_a), 0);
        send_frame(0, frame_a(8'h12), 10, lat);
        check_a("after break", 1, 8'h12, 1'b0, 1'b0);
        checkOutput("frame_err sticky", 32'(fe_a), 1);
        pulse_clr(0);
        checkOutput("frame_err cleared", 32'(fe_a), 0);
        do_read(0);
        check_a("after break read", 0, 8'h00, 1'b0, 1'b0);

        $display("[TB] parity instance");
        send_frame(1, frame_b(7'h3C, 1'b1), 11, lat);
        check_b("bad parity", 0, 7'h00, 1'b1);
        pulse_clr(1);
        checkOutput("parity_err cleared", 32'(pe_b), 0);
        send_frame(1, frame_b(7'h3C, 1'b0), 11, lat);
        checkRange("7E2 latency", lat, LAT_B);
        check_b("good 3C", 1, 7'h3C, 1'b0);
        send_frame(1, frame_b(7'h5A, 1'b0), 11, lat);
        check_b("good 5A", 2, 7'h3C, 1'b0);
        do_read(1);
        check_b("read 3C", 1, 7'h5A, 1'b0);
        do_read(1);
        check_b("read 5A", 0, 7'h00, 1'b0);

        $display("[TB] random 8N1 traffic");
        ov_model = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_read(0);
                if (q_a.size() > 0) void'(q_a.pop_front());
            end else begin
                d8 = 8'($urandom);
                send_frame(0, frame_a(d8), 10, lat);
                if (q_a.size() < 4) q_a.push_back(d8);
                else                ov_model = 1'b1;
            end
            check_a($sformatf("randA%0d", i), q_a.size(), head_a(), q_a.size() == 4, ov_model);
        end

        // Push into a full FIFO on the same edge as a pop
        pulse_clr(0);
        ov_model = 1'b0;
        for (int k = 0; k < 4; k++) begin
            do_read(0);
            if (q_a.size() > 0) void'(q_a.pop_front());
        end
        for (int k = 0; k < 4; k++) begin
            d8 = 8'h11 + 8'(k);
            send_frame(0, frame_a(d8), 10, lat);
            q_a.push_back(d8);
        end
        check_a("prefill", 4, 8'h11, 1'b1, 1'b0);
        fork
            send_frame(0, frame_a(8'hC3), 10, lat);
            begin
                repeat (LAT_A - 1) @(posedge clk_in);
                @(negedge clk_in);
                rd_a = 1'b1;
                @(negedge clk_in);
                rd_a = 1'b0;
            end
        join
        void'(q_a.pop_front());
        q_a.push_back(8'hC3);
        check_a("push pop full", 4, head_a(), 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("drain%0d dout", k), 32'(dout_a), 32'(q_a[0]));
            do_read(0);
            void'(q_a.pop_front());
        end
        check_a("drained", 0, 8'h00, 1'b0, 1'b0);

        $display("[TB] random 7E2 traffic");
        pe_model = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_read(1);
                if (q_b.size() > 0) void'(q_b.pop_front());
            end else begin
                d7  = 7'($urandom);
                bad = ($urandom_range(0, 3) == 0);
                send_frame(1, frame_b(d7, bad), 11, lat);
                if (bad)                pe_model = 1'b1;
                else if (q_b.size() < 16) q_b.push_back(d7);
            end
            check_b($sformatf("randB%0d", i), q_b.size(), head_b(), pe_model);
        end

        $display("[TB] asynchronous reset mid-frame");
        send_frame(1, frame_b(7'h01, 1'b1), 11, lat);
        send_frame(0, frame_a(8'h33), 10, lat);
        checkOutput("pre-reset count", 32'(count_a), 1);
        applyStimulus(0, frame_a(8'h7E), 5);
        #2 rst = 1'b1;
        #1;
        check_a("mid reset", 0, 8'h00, 1'b0, 1'b0);
        checkOutput("mid reset flags a", {30'b0, pe_a, fe_a}, 0);
        check_b("mid reset", 0, 7'h00, 1'b0);
        line_a = 1'b1;
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        q_a.delete();
        q_b.delete();
        repeat (5) @(negedge clk_in);
        send_frame(0, frame_a(8'h7E), 10, lat);
        check_a("post reset 7E", 1, 8'h7E, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo_param.md
# uart_rx_fifo_param

Parametrised UART receiver with an integrated receive FIFO, the next generation of the fixed 8N1 receive-plus-FIFO block. It deserialises `rx_serial_data` with its own bit-timing counter, so no shared `baud_gen` enable is needed. It supports configurable data width, parity and stop bits, and reports parity, framing and overrun errors. It sits between the board RX pin and the consumer logic that drains bytes with `rd_en`.

## Interface
- `CLK_DIV`, 434: `clk_in` cycles per bit (50 MHz / 115200); must be ≥ 8.
- `DATA_BITS`, 8: data bits per frame, 5–9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: power of two, ≥ 2; `AW` = log2(`FIFO_DEPTH`).
- `AE_TH`, 1: `almost_empty` asserts when `count` ≤ `AE_TH`.
- `clk_in`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_serial_data`  in  1  asynchronous serial line, idle high.
- `rd_en`  in  1  pops the FIFO head.
- `err_clr`  in  1  clears the sticky error flags.
- `dout`  out  `DATA_BITS`  FIFO head (first-word-fall-through).
- `empty`  out  1  FIFO holds 0 entries.
- `almost_empty`  out  1  `count` ≤ `AE_TH`.
- `full`  out  1  `count` == `FIFO_DEPTH`.
- `count`  out  `AW`+1  occupancy.
- `parity_err`  out  1  sticky: a frame was dropped for bad parity.
- `frame_err`  out  1  sticky: a frame was dropped for a low stop bit.
- `overrun`  out  1  sticky: a good frame was dropped because the FIFO was full.

## Operation
- **Input conditioning**
  - `rx_serial_data` passes through a 2-FF synchroniser (reset to 1).
  - A falling edge is detected against the registered previous sample (reset to 1).
- **FSM states:** IDLE, START, DATA, PAR, STOP, WAIT_HI.
- **IDLE:** on a falling edge, load the bit counter with `CLK_DIV`/2 and go to START.
- **START:** at counter expiry (mid start bit):
  - line high: false start, return to IDLE with no flags.
  - line low: reload `CLK_DIV` and go to DATA.
- **DATA:** sample at each expiry and shift in LSB first.
  - After `DATA_BITS` samples, go to PAR if `PARITY` ≠ 0, else STOP.
- **PAR:** sample once.
  - Odd parity requires an odd count of 1s across data plus parity bit.
  - Even parity requires an even count.
- **STOP:** sample `STOP_BITS` times, one per expiry. Any low stop sample marks a framing error.
- **Frame decision** (at the last stop sample, in priority order):
  - Framing error: set `frame_err`, discard the byte, go to WAIT_HI.
  - Else parity error: set `parity_err`, discard, go to IDLE.
  - Else push the byte. If the FIFO is full and `rd_en` is low, drop the byte and set `overrun`. Go to IDLE.
- **WAIT_HI:** stay until the synchronised line is high, then go to IDLE. A break never produces repeated frames.
- **FIFO**
  - `FIFO_DEPTH` entries with wrapping `AW`-bit pointers.
  - `dout` shows the head whenever `empty` = 0.
  - `rd_en` while empty is ignored.
  - A push and pop in the same cycle is accepted even when full; `count` is unchanged.
- **Error flags:** sticky until `err_clr`. A set event in the same cycle as `err_clr` wins.
- **Reset** (asynchronous, any time including mid-frame):
  - FSM to IDLE, pointers to 0.
  - `dout` = 0, `empty` = 1, `almost_empty` = 1, `full` = 0, `count` = 0, all error flags 0.
  - A partial frame is lost.
  - Reception restarts only after a high-to-low transition seen after reset release.

## Timing
- Falling edge at the pin to START entry: 3 cycles (2 sync + 1 edge register).
- Mid-bit sample points are offset `CLK_DIV`/2 + k·`CLK_DIV` cycles from START entry.
- Pin falling edge to FIFO write: 3 + `CLK_DIV`/2 + `CLK_DIV`·(`DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`) cycles. Bench tolerance is ±2.
- FIFO write to `empty`/`count`/`dout` update: 1 cycle, all registered.
- `rd_en` sampled at edge N: head and `count` update at edge N; the next head is on `dout` after edge N.
- Error flags assert on the edge of the frame decision.
- Maximum throughput is one frame per frame time. The FSM returns to IDLE half a bit before the stop bit ends, so back-to-back frames are accepted.

## Test plan
- `CLK_DIV`=16, 8N1: send 0xA5 → `empty` 1→0, `dout`=0xA5, `count`=1; one `rd_en` pulse → `empty`=1, `count`=0.
- `PARITY`=2: send 0x3C with parity bit 1 (wrong) → `parity_err`=1, `empty` stays 1. Pulse `err_clr` → 0. Resend 0x3C with parity 0 → `dout`=0x3C.
- Send 0x55 with the stop bit held low for 3 bit times → `frame_err`=1, no push, no further frame until the line returns high. Then 0x12 is received correctly.
- `FIFO_DEPTH`=4, no reads: send 0x01..0x05 → `full`=1 after 0x04, `overrun`=1 after 0x05. Four reads return 0x01, 0x02, 0x03, 0x04, then `empty`=1.
- Low glitch of 4 cycles (`CLK_DIV`=16) → no push, all error flags 0. `DATA_BITS`=7 with `STOP_BITS`=2: send 0x5A → `dout`=0x5A.
- Assert `rst` mid data bits of a frame → outputs take reset values immediately. Release and send 0x7E → `dout`=0x7E, `count`=1.
